// File: rtl/msub_pkg.sv
// +--------------------------------------------------------------------------+
// | msub_pkg : shared state encoding and counter sizing for the multi-word  |
// |            subtractor.                                                    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package msub_pkg;

  typedef enum logic [0:0] {
    MSUB_IDLE = 1'b0,
    MSUB_BUSY = 1'b1
  } msub_state_t;

  // Smallest width able to hold values 0..v-1; called with WORDS+1 so the
  // beat counter can represent WORDS itself.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sub_word_stage.sv
// +--------------------------------------------------------------------------+
// | sub_word_stage : combinational N-bit ripple-borrow subtract with signed   |
// |                  overflow.                                                |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sub_word_stage #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  output logic [N-1:0] z,
  output logic         b,
  output logic         v
);

  logic [N:0] w_bor;

  assign w_bor[0] = bin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign z[i]       = x[i] ^ y[i] ^ w_bor[i];
    assign w_bor[i+1] = (~x[i] & y[i]) | (~x[i] & w_bor[i]) | (y[i] & w_bor[i]);
  end

  assign b = w_bor[N];
  assign v = (x[N-1] ^ y[N-1]) & (x[N-1] ^ z[N-1]);

endmodule

`default_nettype wire

// File: rtl/multiword_subtractor_seq.sv
// +--------------------------------------------------------------------------+
// | multiword_subtractor_seq : streaming multi-precision X - Y, LS word first,|
// |   one registered result word per accepted beat. Optional zero flag is     |
// |   built when MSUB_ZERO_FLAG_EN is defined.                                |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module multiword_subtractor_seq
  import msub_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_y,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_z,
  output logic         out_last,
  output logic         out_b,
  output logic         out_v,
  output logic         out_zero,
  output logic         err
);

  localparam int                 c_CNT_W = clog2(WORDS + 1);
  localparam logic [c_CNT_W-1:0] c_WORDS = c_CNT_W'(WORDS);

  msub_state_t        r_state;
  msub_state_t        w_state_next;
  logic               r_borrow;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_out_valid;
  logic [N-1:0]       r_out_z;
  logic               r_out_last;
  logic               r_out_b;
  logic               r_out_v;
  logic               r_err;

  logic               w_accept;
  logic               w_first;
  logic               w_proto_err;
  logic               w_bin;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic               w_forced;
  logic               w_last;
  logic [N-1:0]       w_z;
  logic               w_b;
  logic               w_v;

  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  // Any beat seen in IDLE starts a new operand, even without in_first.
  assign w_first     = in_first | (r_state == MSUB_IDLE);
  assign w_proto_err = (in_first & (r_state == MSUB_BUSY)) |
                       (~in_first & (r_state == MSUB_IDLE));
  assign w_bin       = w_first ? 1'b0 : r_borrow;
  assign w_cnt_next  = (w_first ? '0 : r_cnt) + 1'b1;
  assign w_forced    = (w_cnt_next == c_WORDS) & ~in_last;
  assign w_last      = in_last | w_forced;

  sub_word_stage #(
    .N (N)
  ) u_stage (
    .x   (in_x),
    .y   (in_y),
    .bin (w_bin),
    .z   (w_z),
    .b   (w_b),
    .v   (w_v)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = w_last ? MSUB_IDLE : MSUB_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MSUB_IDLE;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_last  <= 1'b0;
      r_out_b     <= 1'b0;
      r_out_v     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_borrow    <= w_b;
        r_cnt       <= w_last ? '0 : w_cnt_next;
        r_out_valid <= 1'b1;
        r_out_z     <= w_z;
        r_out_last  <= w_last;
        r_out_b     <= w_b;
        r_out_v     <= w_last & w_v;
        if (w_proto_err | w_forced) r_err <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef MSUB_ZERO_FLAG_EN
  logic [N-1:0] r_zacc;
  logic [N-1:0] w_zacc_base;
  logic         r_out_zero;

  assign w_zacc_base = w_first ? '0 : r_zacc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zacc     <= '0;
      r_out_zero <= 1'b0;
    end else if (w_accept) begin
      r_zacc     <= w_zacc_base | w_z;
      r_out_zero <= w_last & ~(|(w_zacc_base | w_z));
    end
  end

  assign out_zero = r_out_zero;
`else
  assign out_zero = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign out_last  = r_out_last;
  assign out_b     = r_out_b;
  assign out_v     = r_out_v;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_multiword_subtractor_seq.sv
// +--------------------------------------------------------------------------+
// | tb_multiword_subtractor_seq : directed and random stimulus against a      |
// |   whole-operand arithmetic reference model.                               |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multiword_subtractor_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
`ifdef MSUB_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] z;
    logic         last;
    logic         b;
    logic         v;
    logic         zero;
  } word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_x;
  logic [N-1:0] in_y;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_z;
  logic         out_last;
  logic         out_b;
  logic         out_v;
  logic         out_zero;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  multiword_subtractor_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_last  (out_last),
    .out_b     (out_b),
    .out_v     (out_v),
    .out_zero  (out_zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Consumer ready: random or held at a fixed level.
  logic rnd_ready  = 1'b0;
  logic hold_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : hold_ready;
  end

  // Reference model: keeps the whole operands as integers and derives each
  // result word from the full-width difference.
  word_t       q[$];
  word_t       obs[$];
  int          k = 0;
  logic [63:0] mx, my;
  logic        exp_err = 1'b0;
  logic        have_prev = 1'b0;
  word_t       prev;

  function automatic longint sext(input logic [63:0] a, input int w);
    longint r;
    r = longint'(a);
    if (a[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  task automatic model_push(input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic f, input logic l);
    word_t       e;
    int          w;
    logic [63:0] d;
    longint      sd;
    if (f && k > 0) exp_err = 1'b1;
    if (!f && k == 0) exp_err = 1'b1;
    if (f || k == 0) begin
      k  = 0;
      mx = 64'd0;
      my = 64'd0;
    end
    mx = mx | (64'(x) << (N * k));
    my = my | (64'(y) << (N * k));
    k++;
    w = N * k;
    d = (mx - my) & ((64'd1 << w) - 64'd1);
    e.z    = N'(d >> (N * (k - 1)));
    e.b    = (mx < my);
    e.last = l || (k == WORDS);
    if (!l && k == WORDS) exp_err = 1'b1;
    sd     = sext(mx, w) - sext(my, w);
    e.v    = e.last && ((sd < -(longint'(1) << (w - 1))) || (sd >= (longint'(1) << (w - 1))));
    e.zero = e.last && ZF && (mx == my);
    q.push_back(e);
    if (e.last) k = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      k         = 0;
      exp_err   = 1'b0;
      have_prev = 1'b0;
    end else begin
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, !out_valid || out_ready);
      check("err", err, exp_err);
      if (have_prev) begin
        check("hold_z", out_z, prev.z);
        check("hold_last", out_last, prev.last);
        check("hold_b", out_b, prev.b);
        check("hold_v", out_v, prev.v);
      end
      have_prev = out_valid && !out_ready;
      prev.z = out_z; prev.last = out_last; prev.b = out_b; prev.v = out_v;
      if (out_valid && q.size() > 0) begin
        check("out_z", out_z, q[0].z);
        check("out_last", out_last, q[0].last);
        if (q[0].last) begin
          check("out_b", out_b, q[0].b);
          check("out_v", out_v, q[0].v);
          check("out_zero", out_zero, q[0].zero);
        end
        if (out_ready) begin
          obs.push_back('{z: out_z, last: out_last, b: out_b, v: out_v, zero: out_zero});
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) model_push(in_x, in_y, in_first, in_last);
    end
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                      input logic f, input logic l);
    bit ok;
    in_valid = 1'b1; in_x = x; in_y = y; in_first = f; in_last = l;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() > 0; t++) @(negedge clk);
    check("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string tag, input int idx, input logic [N-1:0] z);
    if (idx < obs.size()) check(tag, obs[idx].z, z);
    else check({tag, "_missing"}, obs.size(), idx + 1);
  endtask

  int t0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_first = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_z", out_z, 0);
    check("rst_flags", {out_last, out_b, out_v, out_zero, err}, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Two-word 0x1234 - 0x0135
    obs.delete();
    send(8'h34, 8'h35, 1, 0);
    send(8'h12, 8'h01, 0, 1);
    drain();
    check_obs("t1_w0", 0, 8'hFF);
    check_obs("t1_w1", 1, 8'h10);
    if (obs.size() > 1) check("t1_bvz", {obs[1].b, obs[1].v, obs[1].zero}, 0);

    // Single-word operands
    obs.delete();
    send(8'h7F, 8'h80, 1, 1);
    send(8'h05, 8'h0A, 1, 1);
    drain();
    check_obs("t2_z0", 0, 8'hFF);
    check_obs("t2_z1", 1, 8'hFB);
    if (obs.size() > 1) begin
      check("t2_bv0", {obs[0].b, obs[0].v}, 2'b11);
      check("t2_bv1", {obs[1].b, obs[1].v}, 2'b10);
    end

    // Zero result
    obs.delete();
    send(8'h05, 8'h05, 1, 0);
    send(8'h05, 8'h05, 0, 1);
    drain();
    if (obs.size() > 1) check("t3_zero", obs[1].zero, ZF);
    else check("t3_missing", obs.size(), 2);

    // Back-pressure for three cycles, then back-to-back beats
    hold_ready = 1'b0;
    @(posedge clk); #1;
    send(8'h10, 8'h01, 1, 1);
    in_valid = 1'b1; in_x = 8'h20; in_y = 8'h02; in_first = 1'b1; in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
    end
    hold_ready = 1'b1;
    send(8'h20, 8'h02, 1, 1);
    t0 = int'($time);
    send(8'h01, 8'h02, 1, 0);
    send(8'h03, 8'h04, 0, 0);
    send(8'h05, 8'h06, 0, 0);
    send(8'h07, 8'h08, 0, 1);
    check("b2b_cycles", int'($time) - t0, 40);
    drain();

    // Forced last at WORDS, fifth beat restarts with borrow-in 0
    obs.delete();
    send(8'h11, 8'h01, 1, 0);
    send(8'h22, 8'h02, 0, 0);
    send(8'h33, 8'h03, 0, 0);
    send(8'h00, 8'h01, 0, 0);
    send(8'h05, 8'h03, 0, 0);
    send(8'h00, 8'h00, 0, 1);
    drain();
    if (obs.size() > 4) begin
      check("t5_forced_last", obs[3].last, 1);
      check("t5_restart_z", obs[4].z, 8'h02);
      check("t5_restart_last", obs[4].last, 0);
    end else check("t5_missing", obs.size(), 6);
    check("t5_err", err, 1);

    // Reset mid-operand
    send(8'h55, 8'h11, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_err", err, 0);
    @(posedge clk); #1;
    obs.delete();
    send(8'h00, 8'h01, 1, 0);
    send(8'h01, 8'h00, 0, 1);
    drain();
    check_obs("t6_w0", 0, 8'hFF);
    check_obs("t6_w1", 1, 8'h00);
    if (obs.size() > 1) check("t6_b", obs[1].b, 0);

    // Random operands, random back-pressure, occasional flag corruption
    rnd_ready = 1'b1;
    for (int op = 0; op < 150; op++) begin
      int len;
      len = $urandom_range(1, WORDS);
      for (int w = 0; w < len; w++) begin
        logic f, l;
        f = (w == 0);
        l = (w == len - 1);
        if ($urandom_range(0, 19) == 0) f = ~f;
        if ($urandom_range(0, 19) == 0) l = ~l;
        send(N'($urandom), N'($urandom), f, l);
      end
    end
    rnd_ready = 1'b0;
    hold_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiword_subtractor_seq.md
# multiword_subtractor_seq

Sequential multi-precision subtractor. Accepts two long operands as a stream of N-bit word pairs, least-significant word first, and produces X − Y one word per accepted beat. A borrow register carries the borrow between words. Sits directly upstream of the result consumer: it feeds word-wide operands and a chained borrow into an N-bit ripple-borrow subtract stage and registers that stage's difference, borrow and overflow outputs.

## Interface
- N, 8, word width in bits (≥2)
- WORDS, 4, maximum words per operand (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand word pair present
- in_ready  output  1  block can accept a word pair this cycle
- in_x  input  N  minuend word
- in_y  input  N  subtrahend word
- in_first  input  1  beat is least-significant word of a new operand
- in_last  input  1  beat is most-significant word
- out_valid  output  1  result word present
- out_ready  input  1  consumer accepts result word
- out_z  output  N  difference word
- out_last  output  1  final word of result
- out_b  output  1  final borrow out; meaningful only when out_last=1
- out_v  output  1  signed overflow of full-width result; meaningful only when out_last=1
- out_zero  output  1  entire result is zero; meaningful only when out_last=1
- err  output  1  sticky protocol error

## Operation
- A beat is accepted when in_valid & in_ready. A result word is consumed when out_valid & out_ready.
- in_ready = !out_valid | out_ready. This is a single output register, so full throughput is possible with no bubbles.
- State machine:
  - IDLE: waiting for a first word.
  - BUSY: mid-operand.
  - IDLE→BUSY on an accepted non-last beat.
  - BUSY→IDLE on an accepted last beat, or on a forced last.
  - Single-word operand (in_first=1, in_last=1): stays in IDLE.
- Borrow-in per word:
  - 0 for a first beat.
  - Otherwise the registered borrow-out of the previous word.
- Word arithmetic:
  - {b, z} = {1'b0, x} − {1'b0, y} − bin, computed modulo 2^N.
  - b=1 when x < y + bin (unsigned).
- Overflow is computed on the last word only: v = (x[N-1]^y[N-1]) & (x[N-1]^z[N-1]).
- Zero flag: an accumulator ORs every z word of the operand. out_zero = ~(acc | z_last). The accumulator clears on each first beat.
- Beat counter: counts accepted beats of the current operand.
  - If the WORDS-th beat arrives with in_last=0, it is forced last: out_last=1, state→IDLE, err←1.
  - Any following non-first beats are then handled by the IDLE rule below.
- Protocol errors (each sets err):
  - in_first=1 in BUSY: the current operand is abandoned. The beat starts a new operand with borrow-in 0, and the counter and zero accumulator clear.
  - in_first=0 in IDLE: the beat is treated as a first beat, with borrow-in 0.
- err is cleared only by rst.

## Timing
- Latency is 1 cycle. out_z, out_b, out_v, out_zero and out_last are registered on the cycle the beat is accepted and are visible on the next cycle.
- With out_valid=1 and out_ready=0, all out_* outputs hold stable and in_ready=0.
- Simultaneous consume and accept: the output register reloads in the same cycle, and out_valid stays 1.
- Reset values: out_valid=0, out_z=0, out_last=0, out_b=0, out_v=0, out_zero=0, err=0, borrow reg=0, counter=0, zero accumulator=0, state=IDLE. in_ready=1 in the cycle after reset.
- Reset mid-operand discards the partial result. No partial word is emitted afterwards.

## Configuration
- MSUB_ZERO_FLAG_EN defined: the zero accumulator is instantiated and out_zero behaves as specified above.
- MSUB_ZERO_FLAG_EN undefined: there is no accumulator register and out_zero is tied to 0.
- All other behaviour is identical in both cases.

## Structure
- Shared package msub_pkg holds:
  - the state enum (MSUB_IDLE, MSUB_BUSY)
  - the counter-width function clog2(WORDS+1)
- Sub-module sub_word_stage: combinational N-bit ripple-borrow subtract. Inputs x, y, bin; outputs z, b, v. Instantiated once.

## Test plan
- N=8, beats (x=0x34,y=0x35,first) then (0x12,0x01,last) → out_z 0xFF then 0x10; final out_b=0, out_v=0, out_zero=0.
- Single beat x=0x7F, y=0x80, first+last → out_z=0xFF, out_b=1, out_v=1. Single beat x=0x05, y=0x0A → out_z=0xFB, out_b=1, out_v=0.
- Two beats 0x05−0x05, 0x05−0x05 → out_z 0x00, 0x00; out_zero=1. Without MSUB_ZERO_FLAG_EN, out_zero=0.
- out_ready held low for 3 cycles after the first result → out_* stable and in_ready=0. Release → back-to-back beats at one per cycle with no loss.
- WORDS=4, five beats with no in_last → 4th result has out_last=1 and err=1. 5th beat is treated as a first beat with borrow-in 0.
- rst asserted after the first word of a two-word operand → out_valid=0 and err=0 next cycle. A new operand 0x0100−0x0001 then yields 0xFF, 0x00 with out_b=0.
